// File: rtl/hls_call_pkg.sv
// Shared definitions for the call initiator that drives a generated
// start/finished/return_val function module.
//
// Contents:
//   DEFAULT_DATA_W  default width of return_val / rsp_data
//   DEFAULT_CNT_W   default width of the cycle counter / rsp_cycles
//   call_state_e    initiator FSM state encoding (3 bits)
package hls_call_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CRST  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } call_state_e;

endpackage

// File: rtl/call_cycle_counter.sv
// Clearable, enabled, saturating cycle counter with a limit compare.
// at_limit_o looks one step ahead: it is high on the cycle whose count,
// once incremented, equals limit_i. That lets the owner leave a phase on
// exactly the limit-th cycle of that phase.
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset (count -> 0)
//   clear_i    force count to 0 on the next edge (wins over en_i)
//   en_i       increment once per cycle, saturating at all-ones
//   limit_i    compare value
//   count_o    current count
//   at_limit_o count_o + 1 == limit_i
module call_cycle_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] count_o,
    output logic             at_limit_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W:0]   count_plus1;

    // One extra bit so the look-ahead compare cannot wrap when saturated.
    assign count_plus1 = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
    assign at_limit_o  = (count_plus1 == {1'b0, limit_i});
    assign count_o     = count_q;

    // Next count: clear has priority, otherwise count up and stick at max.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !(&count_q)) begin
            count_d = count_plus1[CNT_W-1:0];
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hls_call_initiator.sv
// Caller side of the start/finished/return_val interface of a generated
// function module. A host request (valid/ready, no payload) makes the
// initiator hold the callee in reset for RST_CYCLES, pulse start for one
// cycle, then wait for finished or a timeout. The return value and the
// number of wait cycles come back to the host over valid/ready. The callee
// is kept in reset whenever no call is in flight, which also clears its
// sticky finished flag between calls.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/req_ready host call request (req_ready decoded from state)
//   rsp_valid/rsp_ready result handshake
//   rsp_data            captured return_val, 0 on timeout
//   rsp_cycles          wait cycles until finished, or TIMEOUT_CYCLES
//   rsp_timeout         call did not finish in time
//   callee_reset        callee reset
//   callee_start        callee start pulse
//   callee_finished     callee finished (level, sticky)
//   callee_return_val   callee result, valid while finished
module hls_call_initiator
    import hls_call_pkg::*;
#(
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int CNT_W          = DEFAULT_CNT_W,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int RST_CYCLES     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [CNT_W-1:0]  rsp_cycles,
    output logic              rsp_timeout,
    output logic              callee_reset,
    output logic              callee_start,
    input  logic              callee_finished,
    input  logic [DATA_W-1:0] callee_return_val
);

    localparam logic [CNT_W-1:0] RST_LIMIT     = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    call_state_e       state_q, state_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]  rsp_cycles_q, rsp_cycles_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              callee_reset_q, callee_reset_d;
    logic              callee_start_q, callee_start_d;

    logic              cnt_clear;
    logic              cnt_en;
    logic [CNT_W-1:0]  cnt_limit;
    logic [CNT_W-1:0]  cnt_value;
    logic              cnt_at_limit;
    logic [CNT_W-1:0]  cnt_inc;

    // One counter serves both timed phases: the reset hold in CRST and the
    // timeout in WAIT. It is cleared outside those phases so each phase
    // starts counting from 0 on its first cycle.
    assign cnt_clear = (state_q == IDLE) || (state_q == START) || (state_q == RESP);
    assign cnt_en    = (state_q == CRST) || (state_q == WAIT);
    assign cnt_limit = (state_q == CRST) ? RST_LIMIT : TIMEOUT_LIMIT;
    assign cnt_inc   = cnt_value + CNT_W'(1);

    call_cycle_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (cnt_clear),
        .en_i      (cnt_en),
        .limit_i   (cnt_limit),
        .count_o   (cnt_value),
        .at_limit_o(cnt_at_limit)
    );

    // req_ready is the only unregistered output; reset masks it directly so
    // the host never sees a ready while the block is being reset.
    assign req_ready    = (state_q == IDLE) && !reset;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_cycles   = rsp_cycles_q;
    assign rsp_timeout  = rsp_timeout_q;
    assign callee_reset = callee_reset_q;
    assign callee_start = callee_start_q;

    // Next-state and next-output logic. Outputs are derived from the next
    // state so that the registered outputs line up with the state they
    // belong to. callee_finished is only looked at in WAIT; a finished on
    // the final allowed cycle takes priority over the timeout.
    always_comb begin
        state_d       = state_q;
        rsp_data_d    = rsp_data_q;
        rsp_cycles_d  = rsp_cycles_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = CRST;
                end
            end
            CRST: begin
                if (cnt_at_limit) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (callee_finished) begin
                    rsp_data_d    = callee_return_val;
                    rsp_cycles_d  = cnt_inc;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (cnt_at_limit) begin
                    rsp_data_d    = '0;
                    rsp_cycles_d  = TIMEOUT_LIMIT;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rsp_valid_d    = (state_d == RESP);
        callee_start_d = (state_d == START);
        callee_reset_d = !((state_d == START) || (state_d == WAIT));
    end

    // State and output registers. Reset drops any call in flight and puts
    // the callee back into reset on the very next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_cycles_q   <= '0;
            rsp_timeout_q  <= 1'b0;
            callee_reset_q <= 1'b1;
            callee_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_cycles_q   <= rsp_cycles_d;
            rsp_timeout_q  <= rsp_timeout_d;
            callee_reset_q <= callee_reset_d;
            callee_start_q <= callee_start_d;
        end
    end

endmodule

// File: tb/tb_hls_call_initiator.sv
// Testbench for hls_call_initiator. A behavioural callee answers each call
// after a programmed number of wait cycles (or runs a small 2*3 multiply).
// A call-level model predicts, from the acceptance cycle and the programmed
// finish point, what every DUT output must be on each cycle; a negedge
// process compares against it. Directed calls then pin the model with
// hand-computed literal results.
module tb_hls_call_initiator;

    localparam int DATA_W  = 32;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 20;
    localparam int RST     = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [CNT_W-1:0]  rsp_cycles;
    logic              rsp_timeout;
    logic              callee_reset;
    logic              callee_start;
    logic              callee_finished;
    logic [DATA_W-1:0] callee_return_val;

    always #5 clk = ~clk;

    hls_call_initiator #(
        .DATA_W        (DATA_W),
        .CNT_W         (CNT_W),
        .TIMEOUT_CYCLES(TIMEOUT),
        .RST_CYCLES    (RST)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .rsp_cycles       (rsp_cycles),
        .rsp_timeout      (rsp_timeout),
        .callee_reset     (callee_reset),
        .callee_start     (callee_start),
        .callee_finished  (callee_finished),
        .callee_return_val(callee_return_val)
    );

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural callee. finishAt is the wait-cycle index k on which
    // finished first reads 1; in multiply mode it computes 2*3 by repeated
    // addition. return_val is garbage while finished is low.
    int          calleeFinishAt = 1000;
    logic [31:0] calleeVal      = 32'h0;
    bit          calleeMult     = 1'b0;
    logic        calleeFin      = 1'b0;
    logic        calleeRun      = 1'b0;
    logic [31:0] calleeRet      = 32'h0;
    int          calleeK        = 0;
    int          multIdx        = 0;
    logic [31:0] multAcc        = 32'h0;

    always @(posedge clk) begin
        if (callee_reset) begin
            calleeFin <= 1'b0;
            calleeRun <= 1'b0;
            calleeK   <= 0;
            multIdx   <= 0;
            multAcc   <= 32'h0;
        end else if (callee_start) begin
            calleeRun <= 1'b1;
            calleeK   <= 0;
            multIdx   <= 0;
            multAcc   <= 32'h0;
            if (!calleeMult && calleeFinishAt == 0) begin
                calleeFin <= 1'b1;
                calleeRet <= calleeVal;
            end
        end else if (calleeRun && !calleeFin) begin
            calleeK <= calleeK + 1;
            if (calleeMult) begin
                multAcc <= multAcc + 32'd2;
                multIdx <= multIdx + 1;
                if (multIdx + 1 == 3) begin
                    calleeFin <= 1'b1;
                    calleeRet <= multAcc + 32'd2;
                end
            end else if (calleeK + 1 == calleeFinishAt) begin
                calleeFin <= 1'b1;
                calleeRet <= calleeVal;
            end
        end
    end

    assign callee_finished   = calleeFin;
    assign callee_return_val = calleeFin ? calleeRet : 32'h5A5A5A5A;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Call-level model state. t = cycles since the acceptance cycle:
    // t=1..RST callee held in reset, t=RST+1 start pulse, then W wait
    // cycles, then the response is offered until the host takes it.
    bit          known       = 1'b0;
    bit          busy        = 1'b0;
    bit          wasReset    = 1'b0;
    int          acceptCyc   = 0;
    int          curW        = 0;
    int          acceptCount = 0;
    int          rspCount    = 0;
    int          lastHsCyc   = -100;
    int          lastAcceptGap = 0;
    logic [31:0] expData     = 32'h0;
    logic [15:0] expCycles   = 16'h0;
    logic        expTmo      = 1'b0;

    // Observed per-call facts for the literal checks.
    bit          obsSeen     = 1'b0;
    logic [31:0] obsData     = 32'h0;
    logic [15:0] obsCycles   = 16'h0;
    logic        obsTmo      = 1'b0;
    logic        obsRespReset = 1'b0;
    int          obsLatency  = 0;
    int          obsStartCnt = 0;
    int          obsRstCnt   = 0;
    int          rspValidCnt = 0;

    // Compare the current cycle against the model, then advance the model
    // with the inputs that will be sampled on the coming edge.
    always @(negedge clk) begin
        int t;
        bit eRdy, eCR, eCS, eRV;
        if (known) begin
            t    = cyc - acceptCyc;
            eRdy = !reset && !busy;
            eCR  = 1'b1;
            eCS  = 1'b0;
            eRV  = 1'b0;
            if (busy) begin
                if (t == RST + 1) begin
                    eCR = 1'b0;
                    eCS = 1'b1;
                end else if (t > RST + 1 && t <= RST + 1 + curW) begin
                    eCR = 1'b0;
                end else if (t > RST + 1 + curW) begin
                    eRV = 1'b1;
                end
            end
            checkOutput("req_ready", req_ready, eRdy);
            checkOutput("callee_reset", callee_reset, eCR);
            checkOutput("callee_start", callee_start, eCS);
            checkOutput("rsp_valid", rsp_valid, eRV);
            if (eRV) begin
                checkOutput("rsp_data", rsp_data, expData);
                checkOutput("rsp_cycles", rsp_cycles, expCycles);
                checkOutput("rsp_timeout", rsp_timeout, expTmo);
            end
            if (wasReset) begin
                checkOutput("reset_rsp_data", rsp_data, 0);
                checkOutput("reset_rsp_cycles", rsp_cycles, 0);
                checkOutput("reset_rsp_timeout", rsp_timeout, 0);
            end
            if (busy) begin
                if (callee_start) obsStartCnt++;
                if (t >= 1 && t <= RST + 1 && callee_reset && obsRstCnt == t - 1) obsRstCnt++;
                if (rsp_valid && !obsSeen) begin
                    obsSeen      = 1'b1;
                    obsLatency   = t;
                    obsData      = rsp_data;
                    obsCycles    = rsp_cycles;
                    obsTmo       = rsp_timeout;
                    obsRespReset = callee_reset;
                end
            end
            if (rsp_valid) rspValidCnt++;
        end

        if (reset) begin
            known    = 1'b1;
            busy     = 1'b0;
            wasReset = 1'b1;
        end else begin
            wasReset = 1'b0;
            if (known && !busy && req_valid) begin
                busy          = 1'b1;
                acceptCyc     = cyc;
                acceptCount++;
                lastAcceptGap = cyc - lastHsCyc;
                obsSeen       = 1'b0;
                obsStartCnt   = 0;
                obsRstCnt     = 0;
                if (calleeFinishAt < TIMEOUT) begin
                    curW      = calleeFinishAt + 1;
                    expData   = calleeVal;
                    expCycles = 16'(curW);
                    expTmo    = 1'b0;
                end else begin
                    curW      = TIMEOUT;
                    expData   = 32'h0;
                    expCycles = 16'(TIMEOUT);
                    expTmo    = 1'b1;
                end
            end else if (known && busy && (cyc - acceptCyc) > RST + 1 + curW && rsp_ready) begin
                busy      = 1'b0;
                rspCount++;
                lastHsCyc = cyc;
            end
        end
    end

    // Bounded waits on model progress; an expired bound counts as a failure.
    task automatic waitAccept(input int target, input string name);
        int n = 0;
        while (acceptCount < target && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({name, "_accept_wait"}, acceptCount >= target, 1);
    endtask

    task automatic waitResp(input int target, input string name);
        int n = 0;
        while (rspCount < target && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({name, "_resp_wait"}, rspCount >= target, 1);
    endtask

    // One complete call with rsp_ready held high.
    task automatic applyStimulus(input int finishAt, input logic [31:0] val, input bit mult, input string name);
        int a, r;
        a              = acceptCount;
        r              = rspCount;
        calleeFinishAt = finishAt;
        calleeVal      = val;
        calleeMult     = mult;
        req_valid      = 1'b1;
        waitAccept(a + 1, name);
        req_valid      = 1'b0;
        waitResp(r + 1, name);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        int a, r, n, vcnt;
        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("req_ready_in_reset", req_ready, 0);
        checkOutput("callee_reset_in_reset", callee_reset, 1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Nominal: finished on the 5th wait cycle with value 6.
        applyStimulus(4, 32'd6, 1'b0, "nominal");
        checkOutput("nominal_data", obsData, 6);
        checkOutput("nominal_cycles", obsCycles, 5);
        checkOutput("nominal_timeout", obsTmo, 0);
        checkOutput("nominal_start_pulses", obsStartCnt, 1);
        checkOutput("nominal_reset_hold", obsRstCnt, 2);
        checkOutput("nominal_latency", obsLatency, 9);

        // Timeout: callee never finishes.
        applyStimulus(1000, 32'h1234, 1'b0, "timeout");
        checkOutput("timeout_data", obsData, 0);
        checkOutput("timeout_cycles", obsCycles, 20);
        checkOutput("timeout_flag", obsTmo, 1);
        checkOutput("timeout_callee_reset_in_resp", obsRespReset, 1);
        checkOutput("timeout_latency", obsLatency, 24);

        // Finished on the last allowed wait cycle wins over the timeout.
        applyStimulus(19, 32'hDEADBEEF, 1'b0, "lastcycle");
        checkOutput("lastcycle_data", obsData, 32'hDEADBEEF);
        checkOutput("lastcycle_cycles", obsCycles, 20);
        checkOutput("lastcycle_timeout", obsTmo, 0);

        // Finished on the very first wait cycle.
        applyStimulus(0, 32'h77, 1'b0, "firstcycle");
        checkOutput("firstcycle_cycles", obsCycles, 1);
        checkOutput("firstcycle_latency", obsLatency, 5);

        // Backpressure with req_valid held high, then a back-to-back call.
        a              = acceptCount;
        r              = rspCount;
        rsp_ready      = 1'b0;
        calleeFinishAt = 2;
        calleeVal      = 32'h11;
        calleeMult     = 1'b0;
        req_valid      = 1'b1;
        waitAccept(a + 1, "bp1");
        n = 0;
        while (!obsSeen && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("bp1_rsp_seen", obsSeen, 1);
        checkOutput("bp1_data", obsData, 32'h11);
        checkOutput("bp1_cycles", obsCycles, 3);
        calleeFinishAt = 6;
        calleeVal      = 32'h22;
        vcnt           = rspValidCnt;
        repeat (10) begin
            @(posedge clk); #1;
            checkOutput("bp_req_ready_low", req_ready, 0);
        end
        checkOutput("bp_valid_held", rspValidCnt - vcnt, 10);
        rsp_ready = 1'b1;
        waitAccept(a + 2, "bp2");
        req_valid = 1'b0;
        checkOutput("bp2_accept_gap", lastAcceptGap, 1);
        waitResp(r + 2, "bp2");
        checkOutput("bp2_data", obsData, 32'h22);
        checkOutput("bp2_cycles", obsCycles, 7);
        checkOutput("bp2_timeout", obsTmo, 0);

        // Reset during wait cycle k=3: the call is dropped silently.
        a              = acceptCount;
        calleeFinishAt = 5;
        calleeVal      = 32'h55;
        req_valid      = 1'b1;
        waitAccept(a + 1, "midreset");
        req_valid = 1'b0;
        n = 0;
        while (callee_start !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("midreset_start_seen", callee_start, 1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        r     = rspCount;
        vcnt  = rspValidCnt;
        reset = 1'b1;
        #1;
        checkOutput("midreset_req_ready_in_reset", req_ready, 0);
        @(posedge clk); #1;
        checkOutput("midreset_rsp_valid", rsp_valid, 0);
        checkOutput("midreset_callee_reset", callee_reset, 1);
        checkOutput("midreset_callee_start", callee_start, 0);
        checkOutput("midreset_req_ready_held", req_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checkOutput("midreset_req_ready_after", req_ready, 1);
        repeat (30) begin
            @(posedge clk); #1;
        end
        checkOutput("midreset_no_response", rspCount - r, 0);
        checkOutput("midreset_no_valid", rspValidCnt - vcnt, 0);

        // Multiply callee: 2*3 by repeated addition, finished at k=3.
        applyStimulus(3, 32'd6, 1'b1, "mult");
        checkOutput("mult_data", obsData, 6);
        checkOutput("mult_timeout", obsTmo, 0);
        checkOutput("mult_cycles_le10", obsCycles <= 16'd10, 1);

        repeat (3) begin
            @(posedge clk); #1;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hls_call_initiator.md
Name: hls_call_initiator

Overview:
- Caller side of the start/finished/return_val interface that our generated `main`-style function modules expose.
- Accepts a call request from a host over valid/ready and holds the callee in reset while idle.
- Releases the callee's reset, pulses start, waits for finished with a timeout, then captures return_val and the elapsed cycle count.
- Returns the result to the host over valid/ready. Sits between testbench/host logic and one generated function module.

Parameters:
- DATA_W, 32: width of callee return_val and rsp_data.
- CNT_W, 16: width of cycle counter and rsp_cycles.
- TIMEOUT_CYCLES, 1000: WAIT cycles allowed before declaring timeout; legal range 1..2^CNT_W-1.
- RST_CYCLES, 2: cycles callee_reset stays high after request acceptance; legal range >=1.

Ports:
- clk  input  1  sole clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  host requests one call.
- req_ready  output  1  initiator can accept a request.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  host consumes result.
- rsp_data  output  DATA_W  captured return_val; 0 on timeout.
- rsp_cycles  output  CNT_W  WAIT cycles until finished was seen, or TIMEOUT_CYCLES on timeout.
- rsp_timeout  output  1  call did not finish in time.
- callee_reset  output  1  drives callee reset.
- callee_start  output  1  drives callee start.
- callee_finished  input  1  callee finished; level, sticky until callee reset.
- callee_return_val  input  DATA_W  callee result; valid while callee_finished=1.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - Registers: state=IDLE, rsp_valid=0, rsp_data=0, rsp_cycles=0, rsp_timeout=0, callee_start=0, callee_reset=1, counters=0.
  - req_ready is forced to 0 while reset=1.
  - All outputs are registered except req_ready, which is a decode of state.
- FSM states: IDLE, CRST, START, WAIT, RESP.
- IDLE:
  - req_ready=1, callee_reset=1.
  - req_valid&&req_ready moves to CRST. The request carries no payload.
- CRST:
  - callee_reset=1 for exactly RST_CYCLES cycles, counted from the first CRST cycle; then START.
  - The callee's finished and return_val are ignored here.
- START:
  - callee_reset=0 and callee_start=1 for exactly one cycle.
  - Wait counter clears to 0; next state is WAIT.
- WAIT:
  - callee_start=0, callee_reset=0. Counter increments once per WAIT cycle.
  - callee_finished is sampled only in WAIT.
  - When callee_finished=1 on a WAIT cycle with count value k (first WAIT cycle has k=0):
    - rsp_data<=callee_return_val, rsp_cycles<=k+1, rsp_timeout<=0, go to RESP.
  - Otherwise, if k+1==TIMEOUT_CYCLES:
    - rsp_data<=0, rsp_cycles<=TIMEOUT_CYCLES, rsp_timeout<=1, go to RESP.
  - Finished and timeout on the same cycle: finished wins (success).
- RESP:
  - rsp_valid=1. rsp_data, rsp_cycles and rsp_timeout are held stable until rsp_valid&&rsp_ready.
  - callee_reset=1 from the first RESP cycle, so the callee's sticky finished is cleared before the next call.
  - On handshake: rsp_valid<=0, go to IDLE.
  - A new request is accepted no earlier than the cycle after the handshake, giving back-to-back throughput of one call per (1+RST_CYCLES+1+W+1+backpressure) cycles.
- Latency: request acceptance to rsp_valid=1 takes RST_CYCLES+2+W cycles, where W = WAIT cycles spent.
- Reset mid-operation (any state): the next cycle shows reset values. Any pending response is discarded; callee_reset=1 immediately.
- Counter: saturating, CNT_W bits; it cannot overflow given the TIMEOUT_CYCLES range.
- No combinational path from any input to any output except reset→req_ready.

Decomposition:
- Shared package hls_call_pkg:
  - FSM state typedef (IDLE, CRST, START, WAIT, RESP; 3 bits).
  - Default DATA_W=32 and CNT_W=16 constants.
  - Reused by the existing start/finished testbenches.
- One sub-module, call_cycle_counter:
  - Clearable, enabled, saturating CNT_W counter.
  - Compares against a limit and outputs `at_limit`.
  - Used for both the CRST hold (limit RST_CYCLES) and the WAIT timeout (limit TIMEOUT_CYCLES).

Test Plan:
- Nominal call: behavioural callee asserts finished with return_val=6 on the 5th WAIT cycle, rsp_ready=1 → rsp_valid for one cycle, rsp_data=6, rsp_cycles=5, rsp_timeout=0, callee_start high for exactly 1 cycle, callee_reset high exactly 2 cycles after acceptance.
- Timeout: TIMEOUT_CYCLES=20, callee never finishes → rsp_timeout=1, rsp_data=0, rsp_cycles=20, and callee_reset=1 from the first RESP cycle.
- Finished on the last allowed cycle: TIMEOUT_CYCLES=20, finished on WAIT k=19 with return_val=0xDEADBEEF → success, rsp_cycles=20, rsp_timeout=0, rsp_data=0xDEADBEEF.
- Backpressure and back-to-back: rsp_ready=0 for 10 cycles, then 1, with req_valid held high → rsp fields stable all 10 cycles, req_ready=0 throughout; second request accepted the cycle after the handshake; callee_reset reasserted between calls; stale finished from call 1 is never sampled in call 2.
- Reset mid-WAIT: assert reset on WAIT k=3 → next cycle rsp_valid=0, callee_reset=1, callee_start=0, req_ready=0 while reset is high and 1 after; no response is ever produced for the aborted call.
- Real callee: connect the generated 2*3 function module → rsp_data=6, rsp_timeout=0, rsp_cycles ≤ 10.
